// File: rtl/dmem_store_buffer_if.sv
`default_nettype none
// ============================================================================
// dmem_store_buffer_if : memory-side request/ack bus of the data store buffer
// Revision 1.0
// ============================================================================
interface dmem_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  modport master (output m_req, m_we, m_addr, m_wdata, input m_rdata, m_ack);
  modport slave  (input m_req, m_we, m_addr, m_wdata, output m_rdata, m_ack);
endinterface
`default_nettype wire

// File: rtl/dmem_store_buffer.sv
`default_nettype none
// ============================================================================
// dmem_store_buffer : posted-write FIFO between core data port and data memory,
//   with store-to-load forwarding when STBUF_FWD_EN is defined.
// Revision 1.0
// ============================================================================
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_we,
  input  logic                mem_re,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wdata,
  output logic [DW-1:0]       rdata,
  output logic                stall,
  dmem_store_buffer_if.master mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = AW - 2;

`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  logic [WW-1:0] tag_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, head_next;
  logic [CW-1:0] count;

  state_t        state, state_nxt;
  logic          req, req_nxt;
  logic          we_q, we_nxt;
  logic [AW-1:0] maddr, maddr_nxt;
  logic [DW-1:0] mwdata, mwdata_nxt;

  logic          full, push, pop, ack, load_req, load_miss, read_done;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign full      = (count == CW'(DEPTH));
  assign push      = mem_we & ~full;
  assign load_req  = mem_re & ~mem_we;
  assign ack       = req & mem.m_ack;
  assign pop       = (state == WRITE) & ack;
  assign read_done = (state == READ) & ack;
  assign load_miss = load_req & ~hit;
  assign head_next = rd_ptr + PW'(1);

`ifdef STBUF_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (tag_q[fwd_idx] == addr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = data_q[fwd_idx];
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_comb begin
    stall = 1'b0;
    rdata = '0;
    if (reset) begin
      stall = (mem_we & full) | (load_miss & ~read_done);
      if (load_req & hit)
        rdata = hit_data;
      else if (load_req & read_done)
        rdata = mem.m_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_nxt    = req;
    we_nxt     = we_q;
    maddr_nxt  = maddr;
    mwdata_nxt = mwdata;
    case (state)
      IDLE: begin
        if (FWD && load_miss) begin
          state_nxt  = READ;
          req_nxt    = 1'b1;
          we_nxt     = 1'b0;
          maddr_nxt  = {2'b00, addr[AW-1:2]};
          mwdata_nxt = '0;
        end else if (count != '0) begin
          state_nxt  = WRITE;
          req_nxt    = 1'b1;
          we_nxt     = 1'b1;
          maddr_nxt  = {2'b00, tag_q[rd_ptr]};
          mwdata_nxt = data_q[rd_ptr];
        end else if (load_miss) begin
          state_nxt  = READ;
          req_nxt    = 1'b1;
          we_nxt     = 1'b0;
          maddr_nxt  = {2'b00, addr[AW-1:2]};
          mwdata_nxt = '0;
        end
      end
      WRITE: begin
        // Without forwarding the FIFO drains fully before a read goes out.
        if (ack) begin
          if (FWD && load_miss) begin
            state_nxt  = READ;
            req_nxt    = 1'b1;
            we_nxt     = 1'b0;
            maddr_nxt  = {2'b00, addr[AW-1:2]};
            mwdata_nxt = '0;
          end else if (count > CW'(1)) begin
            state_nxt  = WRITE;
            req_nxt    = 1'b1;
            we_nxt     = 1'b1;
            maddr_nxt  = {2'b00, tag_q[head_next]};
            mwdata_nxt = data_q[head_next];
          end else if (!FWD && load_miss) begin
            state_nxt  = READ;
            req_nxt    = 1'b1;
            we_nxt     = 1'b0;
            maddr_nxt  = {2'b00, addr[AW-1:2]};
            mwdata_nxt = '0;
          end else begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            we_nxt    = 1'b0;
          end
        end
      end
      READ: begin
        if (ack) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
        we_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      req    <= 1'b0;
      we_q   <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      req    <= req_nxt;
      we_q   <= we_nxt;
      maddr  <= maddr_nxt;
      mwdata <= mwdata_nxt;
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= head_next;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr]  <= addr[AW-1:2];
      data_q[wr_ptr] <= wdata;
    end
  end

  assign mem.m_req   = req;
  assign mem.m_we    = we_q;
  assign mem.m_addr  = maddr;
  assign mem.m_wdata = mwdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
`default_nettype none
// tb_dmem_store_buffer : vector table for load-miss/full-FIFO timing plus
// sequences for forwarding, drain ordering and mid-transaction reset.
module tb_dmem_store_buffer;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;

`ifdef STBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          mem_we = 1'b0;
  logic          mem_re = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          stall;

  dmem_store_buffer_if #(.AW(AW), .DW(DW)) mem_bus ();

  dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_we (mem_we),
    .mem_re (mem_re),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .stall  (stall),
    .mem    (mem_bus)
  );

  always #5 clk = ~clk;

  // Memory model: ack in the lat-th cycle of a request unless held off.
  int          lat = 1;
  logic        hold = 1'b0;
  logic [7:0]  mcnt = '0;
  logic [31:0] mem_arr [64];
  logic [63:0] wr_mask = '0;
  logic [5:0]  midx;
  int          log_n = 0;
  logic        log_we   [128];
  logic [31:0] log_addr [128];
  logic [31:0] log_data [128];

  assign midx = mem_bus.m_addr[5:0];
  assign mem_bus.m_ack = mem_bus.m_req && !hold && (int'(mcnt) >= lat - 1);
  assign mem_bus.m_rdata = wr_mask[midx] ? mem_arr[midx] : (32'hA000_0000 | {26'd0, midx});

  always @(posedge clk) begin
    if (!mem_bus.m_req || mem_bus.m_ack) mcnt <= '0;
    else mcnt <= mcnt + 8'd1;
    if (mem_bus.m_req && mem_bus.m_ack) begin
      if (log_n < 128) begin
        log_we[log_n]   <= mem_bus.m_we;
        log_addr[log_n] <= mem_bus.m_addr;
        log_data[log_n] <= mem_bus.m_we ? mem_bus.m_wdata : mem_bus.m_rdata;
      end
      log_n <= log_n + 1;
      if (mem_bus.m_we) begin
        mem_arr[midx] <= mem_bus.m_wdata;
        wr_mask[midx] <= 1'b1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input int k, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    chk({name, "_we"},   32'(log_we[k]), 32'(we));
    chk({name, "_addr"}, log_addr[k], a);
    chk({name, "_data"}, log_data[k], d);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_re = 1'b0; addr = a; wdata = d;
    #1;
    chk("store_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic do_load(input string name, input logic [31:0] a,
                         input logic [31:0] exp_d, input int exp_stalls);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    mem_we = 1'b0; mem_re = 1'b1; addr = a; wdata = '0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge clk); #1;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_rdata"}, rdata, exp_d);
    chk({name, "_stalls"}, 32'(n), 32'(exp_stalls));
    @(posedge clk); #1;
    mem_re = 1'b0; addr = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] a;
    logic [31:0] d;
    logic        hold;
    int          lat;
    logic        e_stall;
    logic        e_req;
    logic        e_mwe;
    logic [31:0] e_maddr;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [15];
  int   base;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // we re addr   data hold lat | stall req mwe maddr rdata
    tbl[0]  = '{1'b0, 1'b1, 32'd22,    32'd0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 32'h00, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'd22,    32'd0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 32'h05, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'd22,    32'd0, 1'b0, 2, 1'b0, 1'b1, 1'b0, 32'h05, 32'hA000_0005};
    tbl[3]  = '{1'b0, 1'b0, 32'd0,     32'd0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h100,   32'd1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 32'h104,   32'd2, 1'b1, 1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 32'h108,   32'd3, 1'b1, 1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0};
    tbl[7]  = '{1'b1, 1'b0, 32'h10C,   32'd4, 1'b1, 1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h110,   32'd5, 1'b1, 1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'h110,   32'd5, 1'b0, 1, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h110,   32'd5, 1'b0, 1, 1'b0, 1'b1, 1'b1, 32'h41, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'd0,     32'd0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'd0,     32'd0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 32'h43, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'd0,     32'd0, 1'b0, 1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'd0,     32'd0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req",   32'(mem_bus.m_req), 32'd0);
    chk("rst_m_we",    32'(mem_bus.m_we),  32'd0);
    chk("rst_m_addr",  mem_bus.m_addr,     32'd0);
    chk("rst_m_wdata", mem_bus.m_wdata,    32'd0);
    chk("rst_stall",   32'(stall),         32'd0);
    chk("rst_rdata",   rdata,              32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Load miss from empty FIFO, then full-FIFO stall with delayed ack
    base = log_n;
    for (int i = 0; i < 15; i++) begin
      mem_we = tbl[i].we; mem_re = tbl[i].re; addr = tbl[i].a; wdata = tbl[i].d;
      hold = tbl[i].hold; lat = tbl[i].lat;
      #1;
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("vec%0d_m_req", i), 32'(mem_bus.m_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rdata);
      if (tbl[i].e_req) begin
        chk($sformatf("vec%0d_m_we", i), 32'(mem_bus.m_we), 32'(tbl[i].e_mwe));
        chk($sformatf("vec%0d_m_addr", i), mem_bus.m_addr, tbl[i].e_maddr);
      end
      @(posedge clk); #1;
    end
    mem_we = 1'b0; mem_re = 1'b0; addr = '0; wdata = '0;
    chk("tbl_log_n", 32'(log_n - base), 32'd6);
    chk_log("tbl_r", base + 0, 1'b0, 32'h05, 32'hA000_0005);
    chk_log("tbl_w0", base + 1, 1'b1, 32'h40, 32'd1);
    chk_log("tbl_w1", base + 2, 1'b1, 32'h41, 32'd2);
    chk_log("tbl_w2", base + 3, 1'b1, 32'h42, 32'd3);
    chk_log("tbl_w3", base + 4, 1'b1, 32'h43, 32'd4);
    chk_log("tbl_w4", base + 5, 1'b1, 32'h44, 32'd5);

    // Store then load of the same word
    lat = 3;
    base = log_n;
    do_store(32'd4, 32'd5);
    do_load("t1", 32'd4, 32'd5, FWD ? 0 : 6);
    idle(20);
    chk("t1_log_n", 32'(log_n - base), FWD ? 32'd1 : 32'd2);
    chk_log("t1_w", base, 1'b1, 32'd1, 32'd5);

    // Youngest of two matching stores; in-order drain
    base = log_n;
    do_store(32'd13, 32'd10);
    do_store(32'd13, 32'd99);
    do_load("t2", 32'd13, 32'd99, FWD ? 0 : 8);
    idle(20);
    chk("t2_log_n", 32'(log_n - base), FWD ? 32'd2 : 32'd3);
    chk_log("t2_w0", base + 0, 1'b1, 32'd3, 32'd10);
    chk_log("t2_w1", base + 1, 1'b1, 32'd3, 32'd99);

    // Load miss while a write is in flight and two more are queued
    base = log_n;
    do_store(32'h200, 32'h11);
    do_store(32'h204, 32'h22);
    do_store(32'h208, 32'h33);
    do_load("t5", 32'h3F0, 32'hA000_003C, FWD ? 4 : 10);
    idle(25);
    chk("t5_log_n", 32'(log_n - base), 32'd4);
    chk_log("t5_e0", base + 0, 1'b1, 32'h80, 32'h11);
    chk_log("t5_e1", base + 1, FWD ? 1'b0 : 1'b1, FWD ? 32'hFC : 32'h81,
            FWD ? 32'hA000_003C : 32'h22);
    chk_log("t5_e2", base + 2, 1'b1, FWD ? 32'h81 : 32'h82, FWD ? 32'h22 : 32'h33);
    chk_log("t5_e3", base + 3, FWD ? 1'b1 : 1'b0, FWD ? 32'h82 : 32'hFC,
            FWD ? 32'h33 : 32'hA000_003C);

    // Asynchronous reset with stores queued and a request outstanding
    hold = 1'b1;
    do_store(32'h40, 32'h1);
    do_store(32'h44, 32'h2);
    do_store(32'h48, 32'h3);
    chk("t6_req_before", 32'(mem_bus.m_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_req_async",   32'(mem_bus.m_req), 32'd0);
    chk("t6_stall_async", 32'(stall),         32'd0);
    chk("t6_m_we_async",  32'(mem_bus.m_we),  32'd0);
    chk("t6_m_addr_async", mem_bus.m_addr,    32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    hold = 1'b0;
    base = log_n;
    idle(15);
    chk("t6_no_writes", 32'(log_n - base), 32'd0);
    chk("t6_req_after", 32'(mem_bus.m_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
